// File: rtl/vga_fb_reader.sv
// -----------------------------------------------------------------------------
// vga_fb_reader
// Framebuffer fetch stage feeding the VGA timing generator. It mirrors the
// generator's pixel/line counters, prefetches RGB888 words from a memory port
// into a small in-order FIFO, and presents one pixel per pclk during the active
// window. At each frame boundary the FIFO and fetch pointer are flushed and any
// words still in flight are dropped on return, so the next frame always starts
// cleanly at address 0.
//
// Ports
//   pclk        in   pixel clock
//   reset       in   synchronous active-high reset
//   mem_req     out  fetch request valid
//   mem_addr    out  pixel word address (linear index y*width + x)
//   mem_ready   in   request accepted when mem_req & mem_ready
//   mem_rvalid  in   one response word this cycle, in request order
//   mem_rdata   in   response pixel {R,G,B}
//   vga_data    out  pixel to the timing generator (black outside active)
//   underflow   out  sticky: an active pixel was needed while the FIFO was empty
// -----------------------------------------------------------------------------
module vga_fb_reader #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 145,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 36,
    parameter int V_ACT_END   = 515,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 19
) (
    input  logic              pclk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [23:0]       mem_rdata,
    output logic [23:0]       vga_data,
    output logic              underflow
);

    localparam int XW    = $clog2(H_TOTAL + 1);
    localparam int YW    = $clog2(V_TOTAL + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int CW1   = CW + 1;
    localparam int H_ACT = H_ACT_END - H_ACT_START + 1;
    localparam int V_ACT = V_ACT_END - V_ACT_START + 1;

    localparam logic [XW-1:0]     X_LAST    = XW'(H_TOTAL);
    localparam logic [YW-1:0]     Y_LAST    = YW'(V_TOTAL);
    localparam logic [XW-1:0]     X_ACT_LO  = XW'(H_ACT_START);
    localparam logic [XW-1:0]     X_ACT_HI  = XW'(H_ACT_END);
    localparam logic [YW-1:0]     Y_ACT_LO  = YW'(V_ACT_START);
    localparam logic [YW-1:0]     Y_ACT_HI  = YW'(V_ACT_END);
    localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(H_ACT * V_ACT);
    localparam logic [CW1-1:0]    DEPTH_C   = CW1'(FIFO_DEPTH);

    logic [XW-1:0]     x_cnt_r;
    logic [YW-1:0]     y_cnt_r;
    logic [ADDR_W-1:0] pix_addr_r;
    logic [23:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     fifo_count_r;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     drop_r;
    logic              underflow_r;

    logic              active_s;
    logic              flush_s;
    logic              fifo_empty_s;
    logic              credit_ok_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [CW-1:0]     rvalid_ext_s;

    // Pixel/line position, counting exactly like the timing generator
    always_ff @(posedge pclk) begin
        if (reset) begin
            x_cnt_r <= XW'(1);
            y_cnt_r <= YW'(1);
        end else if (x_cnt_r == X_LAST) begin
            x_cnt_r <= XW'(1);
            if (y_cnt_r == Y_LAST) begin
                y_cnt_r <= YW'(1);
            end else begin
                y_cnt_r <= y_cnt_r + YW'(1);
            end
        end else begin
            x_cnt_r <= x_cnt_r + XW'(1);
        end
    end

    // Window decode, credit-based request, FIFO push/pop qualifiers
    always_comb begin
        active_s     = (x_cnt_r >= X_ACT_LO) && (x_cnt_r <= X_ACT_HI) &&
                       (y_cnt_r >= Y_ACT_LO) && (y_cnt_r <= Y_ACT_HI);
        flush_s      = (x_cnt_r == X_LAST) && (y_cnt_r == Y_LAST);
        fifo_empty_s = (fifo_count_r == '0);
        rvalid_ext_s = {{(CW-1){1'b0}}, mem_rvalid};
        // Words already queued plus words in flight must fit the FIFO, so a
        // response can never find the FIFO full.
        credit_ok_s  = ({1'b0, fifo_count_r} + {1'b0, outstanding_r}) < DEPTH_C;
        if (reset) begin
            mem_req = 1'b0;
            pop_s   = 1'b0;
        end else begin
            mem_req = (pix_addr_r < PIX_TOTAL) && credit_ok_s && !flush_s;
            pop_s   = active_s && !fifo_empty_s;
        end
        accept_s = mem_req && mem_ready;
        // Responses arriving on the flush cycle, or owed to the previous frame,
        // never reach the FIFO.
        push_s   = mem_rvalid && !flush_s && (drop_r == '0);
    end

    // FIFO pointers and occupancy; flush empties the FIFO at frame end
    always_ff @(posedge pclk) begin
        if (reset) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else if (flush_s) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge pclk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_rdata;
        end
    end

    // Fetch pointer, in-flight count and stale-response drop counter
    always_ff @(posedge pclk) begin
        if (reset) begin
            pix_addr_r    <= '0;
            outstanding_r <= '0;
            drop_r        <= '0;
        end else if (flush_s) begin
            // mem_req is low here, so nothing new is accepted this cycle
            pix_addr_r    <= '0;
            outstanding_r <= outstanding_r - rvalid_ext_s;
            drop_r        <= outstanding_r - rvalid_ext_s;
        end else begin
            if (accept_s) begin
                pix_addr_r <= pix_addr_r + ADDR_W'(1);
            end
            case ({accept_s, mem_rvalid})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (mem_rvalid && (drop_r != '0)) begin
                drop_r <= drop_r - CW'(1);
            end
        end
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge pclk) begin
        if (reset) begin
            underflow_r <= 1'b0;
        end else if (active_s && fifo_empty_s) begin
            underflow_r <= 1'b1;
        end
    end

    // Pixel to the generator: FIFO head while popping, black otherwise
    always_comb begin
        if (pop_s) begin
            vga_data = fifo_mem_r[rd_ptr_r];
        end else begin
            vga_data = 24'h000000;
        end
    end

    assign mem_addr  = pix_addr_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_vga_fb_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_reader
// Self-checking bench for vga_fb_reader using a reduced screen geometry
// (40x30 total, 16x16 active) so every scenario runs over whole frames.
// A behavioural memory returns rdata = address with a configurable latency and
// ready rate; requested addresses are queued as expected pixels and compared
// as the DUT displays them, alongside position-derived expectations.
// -----------------------------------------------------------------------------
module tb_vga_fb_reader;

    localparam int HT    = 40;
    localparam int HS    = 9;
    localparam int HE    = 24;
    localparam int VT    = 30;
    localparam int VS    = 5;
    localparam int VE    = 20;
    localparam int DEPTH = 16;
    localparam int AW    = 19;
    localparam int W     = HE - HS + 1;
    localparam int NPIX  = W * (VE - VS + 1);

    logic          pclk       = 1'b0;
    logic          reset      = 1'b1;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready  = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [23:0]   mem_rdata  = 24'h000000;
    logic [23:0]   vga_data;
    logic          underflow;

    vga_fb_reader #(
        .H_TOTAL(HT), .H_ACT_START(HS), .H_ACT_END(HE),
        .V_TOTAL(VT), .V_ACT_START(VS), .V_ACT_END(VE),
        .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .pclk(pclk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .vga_data(vga_data), .underflow(underflow)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] exp_data;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rsp_t;

    vec_t        tbl [9];
    rsp_t        rq [$];
    logic [23:0] sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tb_x     = 1;
    int tb_y     = 1;
    int exp_addr = 0;
    int last_due = 0;
    int lat_min  = 2;
    int lat_max  = 2;
    int ready_pct = 100;
    int ufl_mode = 2;       // 0: expect low, 1: expect high, 2: not checked
    int starve_left = 0;
    bit chk_data = 1'b0;
    bit tbl_en = 1'b0;
    bit starve_frame = 1'b0;
    bit flush_frame = 1'b0;
    bit drop_chk = 1'b0;
    bit prev_reset = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d at x=%0d y=%0d cyc=%0d",
                     name, act, exp, tb_x, tb_y, cyc);
        end
    endtask

    // One pixel clock: drive memory inputs, check outputs, advance the model
    task automatic step();
        bit starved;
        bit act_m;
        int due;
        if (starve_frame && tb_x == 1 && tb_y == 10) starve_left = 100;
        starved = (starve_left > 0) ||
                  (flush_frame && tb_y >= VE - 2 && !(tb_y == VT && tb_x >= HT - 3));
        if (starve_left > 0) starve_left--;
        mem_ready = !starved && (int'($urandom_range(99)) < ready_pct);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 24'(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 24'h000000;
        end
        #1;
        act_m = (tb_x >= HS) && (tb_x <= HE) && (tb_y >= VS) && (tb_y <= VE);
        if (reset) begin
            chk("reset_vga_data", vga_data, 0);
            chk("reset_mem_req", mem_req, 0);
            if (prev_reset) chk("reset_underflow", underflow, 0);
        end else begin
            if (prev_reset) begin
                chk("post_reset_vga_data", vga_data, 0);
                chk("post_reset_mem_req", mem_req, 1);
                chk("post_reset_mem_addr", mem_addr, 0);
                chk("post_reset_underflow", underflow, 0);
            end
            if (!act_m) begin
                chk("blank_data", vga_data, 0);
            end else if (chk_data) begin
                chk("pixel_position", vga_data, (tb_y - VS) * W + (tb_x - HS));
                if (sb_q.size() == 0) chk("scoreboard_nonempty", 0, 1);
                else chk("pixel_scoreboard", vga_data, sb_q.pop_front());
            end
            if (tbl_en) begin
                for (int i = 0; i < 9; i++) begin
                    if (tbl[i].x == tb_x && tbl[i].y == tb_y)
                        chk("table_pixel", vga_data, tbl[i].exp_data);
                end
            end
            if (ufl_mode == 0) chk("underflow_low", underflow, 0);
            else if (ufl_mode == 1) chk("underflow_sticky", underflow, 1);
            if (starve_frame) begin
                if (tb_y < 11 || (tb_y == 11 && tb_x <= HS)) chk("starve_underflow_low", underflow, 0);
                else chk("starve_underflow_high", underflow, 1);
                if (act_m && (tb_y == 11 || (tb_y == 12 && tb_x <= 20)))
                    chk("starved_data_black", vga_data, 0);
            end
            if (tb_x == HT && tb_y == VT) chk("flush_req_low", mem_req, 0);
            if (exp_addr >= NPIX) chk("req_after_last", mem_req, 0);
            if (flush_frame && tb_x == HT && tb_y == VT)
                chk("outstanding_at_flush", dut.outstanding_r, 3);
            if (drop_chk && tb_y == 1 && tb_x == 1) chk("drop_after_flush", dut.drop_r, 3);
            if (drop_chk && tb_y == 1 && tb_x == 10) chk("drop_drained", dut.drop_r, 0);
            chk("credit_bound", (int'(dut.fifo_count_r) + int'(dut.outstanding_r)) <= DEPTH, 1);
            if (mem_req && mem_ready) begin
                chk("addr_sequence", mem_addr, exp_addr);
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq.push_back('{addr: mem_addr, due: due});
                sb_q.push_back(24'(exp_addr));
                exp_addr++;
            end
        end
        prev_reset = reset;
        @(posedge pclk);
        cyc++;
        if (reset) begin
            tb_x = 1;
            tb_y = 1;
            exp_addr = 0;
            last_due = 0;
            rq.delete();
            sb_q.delete();
        end else begin
            if (tb_x == HT && tb_y == VT) begin
                exp_addr = 0;
                sb_q.delete();
            end
            if (tb_x == HT) begin
                tb_x = 1;
                tb_y = (tb_y == VT) ? 1 : tb_y + 1;
            end else begin
                tb_x++;
            end
        end
        @(negedge pclk);
    endtask

    task automatic run_frame();
        int n = 0;
        while (!(tb_x == HT && tb_y == VT) && n < HT * VT + 4) begin
            step();
            n++;
        end
        chk("frame_bound", n < HT * VT + 4, 1);
        step();
    endtask

    task automatic run_to(input int x, input int y);
        int n = 0;
        while (!(tb_x == x && tb_y == y) && n < HT * VT + 4) begin
            step();
            n++;
        end
        chk("position_bound", n < HT * VT + 4, 1);
    endtask

    initial begin
        tbl[0] = '{x: HS,     y: VS,     exp_data: 24'd0};
        tbl[1] = '{x: HE,     y: VS,     exp_data: 24'd15};
        tbl[2] = '{x: HS,     y: VS + 1, exp_data: 24'd16};
        tbl[3] = '{x: HE,     y: VE,     exp_data: 24'd255};
        tbl[4] = '{x: HS - 1, y: VS,     exp_data: 24'd0};
        tbl[5] = '{x: HE + 1, y: VS,     exp_data: 24'd0};
        tbl[6] = '{x: HS,     y: VS - 1, exp_data: 24'd0};
        tbl[7] = '{x: HS,     y: VE + 1, exp_data: 24'd0};
        tbl[8] = '{x: HT,     y: VT,     exp_data: 24'd0};

        @(negedge pclk);
        repeat (3) step();
        reset = 1'b0;

        // Ideal memory, one full frame from reset release
        chk_data = 1'b1; tbl_en = 1'b1; ufl_mode = 0;
        run_frame();

        // Backpressure and variable latency
        ready_pct = 90; lat_min = 1; lat_max = 4;
        run_frame();
        run_frame();

        // Starvation mid-frame, then a clean frame from address 0
        ready_pct = 100; lat_min = 2; lat_max = 2;
        chk_data = 1'b0; tbl_en = 1'b0; ufl_mode = 2; starve_frame = 1'b1;
        run_frame();
        starve_frame = 1'b0;
        chk_data = 1'b1; tbl_en = 1'b1; ufl_mode = 1;
        run_frame();

        // Frame end reached with three words in flight
        lat_min = 8; lat_max = 8;
        chk_data = 1'b0; tbl_en = 1'b0; ufl_mode = 2; flush_frame = 1'b1;
        run_frame();
        flush_frame = 1'b0;
        chk_data = 1'b1; tbl_en = 1'b1; ufl_mode = 1; drop_chk = 1'b1;
        run_to(20, 12);
        drop_chk = 1'b0;

        // Reset mid-frame, then a full ideal frame
        lat_min = 2; lat_max = 2; ufl_mode = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Framebuffer fetch stage that sits directly upstream of the VGA timing generator and drives its 24-bit `vga_data` input. It mirrors the generator's 800×525 pixel/line counters, prefetches RGB888 pixels from a memory port into a small in-order FIFO, and presents one pixel per `pclk` during the 640×480 active window. At every frame boundary it resynchronises by flushing stale data, so a transient underflow corrupts at most one frame.

## Interface
- `H_TOTAL`, 800, last value of the pixel counter (counter runs 1..H_TOTAL)
- `H_ACT_START`, 145, first active x (inclusive)
- `H_ACT_END`, 784, last active x (inclusive)
- `V_TOTAL`, 525, last value of the line counter (counter runs 1..V_TOTAL)
- `V_ACT_START`, 36, first active y (inclusive)
- `V_ACT_END`, 515, last active y (inclusive)
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of two, ≥4)
- `ADDR_W`, 19, memory word-address width
- `pclk  in  1  pixel clock`
- `reset  in  1  reset, synchronous, active-high; clock pclk`
- `mem_req  out  1  fetch request valid`
- `mem_addr  out  ADDR_W  pixel word address (linear index y*640+x)`
- `mem_ready  in  1  request accepted when mem_req & mem_ready`
- `mem_rvalid  in  1  one response word this cycle, strictly in request order`
- `mem_rdata  in  24  response pixel {R,G,B}`
- `vga_data  out  24  pixel to the timing generator`
- `underflow  out  1  sticky: active pixel needed while FIFO empty`

## Operation
- Counters `x_cnt`/`y_cnt` reset to 1. Each cycle x increments; at x==H_TOTAL, x←1 and y increments, wrapping V_TOTAL→1. This matches the generator exactly; both blocks share `pclk`/`reset`, so no sync signals are exchanged.
- `active` = (H_ACT_START ≤ x ≤ H_ACT_END) & (V_ACT_START ≤ y ≤ V_ACT_END). This gives 640×480 = 307200 pixels per frame.
- Fetch pointer `pix_addr` (ADDR_W bits) resets to 0. `mem_addr` = `pix_addr`.
- `mem_req` = (`pix_addr` < 307200) & (`fifo_count` + `outstanding` < FIFO_DEPTH) & !`flush`.
  - On accept, `pix_addr`++ and `outstanding`++.
  - The address sequence is strictly 0..307199 per frame.
- On `mem_rvalid`, `outstanding`--.
  - If `drop` > 0: `drop`-- and the data is discarded.
  - Otherwise the data is pushed into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
- Output:
  - When `active` & FIFO non-empty: `vga_data` = FIFO head (from registered storage, no extra latency) and the head is popped this cycle.
  - When `active` & FIFO empty: `vga_data` = 24'h000000, nothing is popped, and `underflow`←1. The flag is cleared only by reset.
  - When not `active`: `vga_data` = 24'h000000.
- Frame flush: `flush` = (x==H_TOTAL & y==V_TOTAL). In that cycle:
  - `fifo_count`←0 and `pix_addr`←0.
  - `mem_req` is forced low; this is the only case where a request may be withdrawn without `mem_ready`.
  - Any `mem_rvalid` that cycle is discarded.
  - `drop` ← `outstanding` − `mem_rvalid`, i.e. all in-flight words at flush are thrown away.
- Push and pop in the same cycle: `fifo_count` is unchanged and the data order is preserved.

## Timing
- Reset values: `mem_req`=0 during reset; `mem_addr`=0, `vga_data`=0, `underflow`=0, `fifo_count`=0, `outstanding`=0, `drop`=0.
- Fetching begins the first cycle after reset deasserts. This leaves 35 lines of lead time before the first active pixel (x=145, y=36).
- The first active pixel is address 0. The pixel at (x, y) is address (y−36)*640 + (x−145).
- The memory must return responses at ≥1 word/cycle on average during active lines. Any response latency L ≥ 1 cycle is tolerated, provided that FIFO_DEPTH covers L plus ready stalls.
- Reset mid-frame: counters, FIFO, `outstanding` and `drop` are all cleared. Responses still returning after reset are outside the contract; the memory must also be reset.

## Test plan
- Reset, then hold: during reset and in the cycle after, `vga_data`=0, `mem_req`=0 during reset, `underflow`=0. `mem_req`=1 with `mem_addr`=0 in the first cycle after release (`mem_ready`=1).
- Ideal memory (ready=1, latency 2, rdata=addr): over a full frame, `vga_data` at (145,36) = 0, at (784,36) = 639, at (145,37) = 640, at (784,515) = 307199. `underflow` stays 0, and outside the active window `vga_data`=0.
- Backpressure (`mem_ready` random 90%, latency 1..4): `mem_addr` stays monotonic, `fifo_count` + `outstanding` never exceeds 16, pixel data is exact, `underflow`=0.
- Starvation (`mem_ready`=0 from y=100 for 2000 cycles): `underflow` rises at the first starved active pixel and stays 1, and `vga_data`=0 while starved. The next frame starts again at address 0.
- Flush with in-flight words (latency 8, frame end reached with `outstanding`=3): the three late responses are discarded (`drop` 3→0), and the next frame's first active pixel = 0.
- Reset asserted at (400,200): all state is cleared, and the following frame timing and data match the ideal-memory case from the first pixel.
